// File: rtl/pq_pkg.sv
// Shared types and sizing helpers for the ping-pong buffer controller.
package pq_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWAP  = 2'd2
    } pq_state_t;

    localparam int PQ_DATA_WIDTH = 8;
    localparam int PQ_ADDR_WIDTH = 4;

    function automatic int pq_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Counters must hold DEPTH itself, so they need one extra bit.
    function automatic int pq_cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/pq_rd_seq.sv
// Drain sequencer: issues bank reads and presents beats with a valid/ready handshake.
module pq_rd_seq
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = PQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = PQ_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drain_pend,
    input  logic [ADDR_WIDTH:0]   drain_len,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] dout2,
    output logic                  rd_en2,
    output logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  last_accept
);

    logic [ADDR_WIDTH:0] rd_cnt;

    // A new read is only issued when the output stage is empty or being emptied.
    assign rd_en2      = !rst && drain_pend && (rd_cnt < drain_len) && (!out_valid || out_ready);
    assign rd_addr2    = rd_cnt[ADDR_WIDTH-1:0];
    assign out_data    = dout2;
    assign last_accept = out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (last_accept) begin
                rd_cnt <= '0;
            end else if (rd_en2) begin
                rd_cnt <= rd_cnt + 1'b1;
            end

            if (rd_en2) begin
                out_valid <= 1'b1;
                out_last  <= (rd_cnt == drain_len - 1'b1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pq_ctrl.sv
// Ping-pong buffer controller: fills one bank from the input stream while draining the other.
// Optional PQ_CTRL_INIT_CLEAR_EN zeroes both banks after reset before streaming starts.
module pq_ctrl
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = PQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = PQ_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  ctrl,
    output logic                  clear,
    output logic                  wr_en1,
    output logic [ADDR_WIDTH-1:0] wr_addr1,
    output logic [DATA_WIDTH-1:0] din1,
    output logic [DATA_WIDTH-1:0] din2,
    output logic                  rd_en2,
    output logic [ADDR_WIDTH-1:0] rd_addr2,
    input  logic [DATA_WIDTH-1:0] dout2,
    output logic                  rd_en1,
    output logic                  wr_en2,
    output logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [ADDR_WIDTH-1:0] wr_addr2,
    output logic                  busy
);

    localparam int DEPTH = pq_depth(ADDR_WIDTH);
    localparam int CW    = pq_cnt_width(ADDR_WIDTH);

`ifdef PQ_CTRL_INIT_CLEAR_EN
    localparam pq_state_t INIT_STATE = ST_CLEAR;
    logic [ADDR_WIDTH-1:0] clr_addr;
`else
    localparam pq_state_t INIT_STATE = ST_RUN;
`endif

    pq_state_t     state, state_nxt;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] drain_len;
    logic          fill_done;
    logic          drain_pend;
    logic          accept;
    logic          last_accept;

    assign din2     = '0;
    assign rd_en1   = 1'b0;
    assign wr_en2   = 1'b0;
    assign rd_addr1 = '0;
    assign wr_addr2 = '0;
    assign busy     = (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        wr_en1    = 1'b0;
        wr_addr1  = fill_cnt[ADDR_WIDTH-1:0];
        din1      = '0;
        clear     = 1'b0;

        case (state)
            ST_CLEAR: begin
`ifdef PQ_CTRL_INIT_CLEAR_EN
                clear    = !rst;
                wr_en1   = !rst;
                wr_addr1 = clr_addr;
                if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
`else
                state_nxt = ST_RUN;
`endif
            end
            ST_RUN: begin
                in_ready = !rst && !fill_done;
                accept   = in_valid && in_ready;
                wr_en1   = accept;
                if (accept) begin
                    din1 = in_data;
                end
                // A full bank waits here until the previous frame has fully left.
                if (fill_done && !drain_pend) begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = INIT_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl       <= 1'b0;
            fill_cnt   <= '0;
            fill_done  <= 1'b0;
            drain_len  <= '0;
            drain_pend <= 1'b0;
        end else if (state == ST_SWAP) begin
            ctrl       <= ~ctrl;
            drain_len  <= fill_cnt;
            drain_pend <= 1'b1;
            fill_cnt   <= '0;
            fill_done  <= 1'b0;
        end else begin
            if (accept) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (in_last || (fill_cnt == CW'(DEPTH - 1))) begin
                    fill_done <= 1'b1;
                end
            end
            if (last_accept) begin
                drain_pend <= 1'b0;
            end
        end
    end

`ifdef PQ_CTRL_INIT_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end
`endif

    pq_rd_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_seq (
        .clk         (clk),
        .rst         (rst),
        .drain_pend  (drain_pend),
        .drain_len   (drain_len),
        .out_ready   (out_ready),
        .dout2       (dout2),
        .rd_en2      (rd_en2),
        .rd_addr2    (rd_addr2),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .last_accept (last_accept)
    );

endmodule

// File: tb/tb_pq_ctrl.sv
// Scoreboard bench for pq_ctrl with an attached ping-pong bank model.
module tb_pq_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef PQ_CTRL_INIT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          ctrl;
    logic          clear;
    logic          wr_en1;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic          rd_en2;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] dout2 = '0;
    logic          rd_en1;
    logic          wr_en2;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] wr_addr2;
    logic          busy;

    pq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ctrl(ctrl), .clear(clear), .wr_en1(wr_en1), .wr_addr1(wr_addr1), .din1(din1), .din2(din2),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .dout2(dout2),
        .rd_en1(rd_en1), .wr_en2(wr_en2), .rd_addr1(rd_addr1), .wr_addr2(wr_addr2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Ping-pong buffer: port 1 writes the bank selected by ctrl, port 2 reads the other.
    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bank0[i] = DW'($urandom);
            bank1[i] = DW'($urandom);
        end
    end
    always @(posedge clk) begin
        if (clear) begin
            bank0[wr_addr1] <= '0;
            bank1[wr_addr1] <= '0;
        end
        if (wr_en1) begin
            if (ctrl) bank1[wr_addr1] <= din1;
            else      bank0[wr_addr1] <= din1;
        end
        if (rd_en2) dout2 <= ctrl ? bank0[rd_addr2] : bank1[rd_addr2];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int tput_len = 0;
    int frames_sent = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) == 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected output stream: accepted input beats, each tagged with its end-of-frame flag.
    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];
    int            model_fill = 0;
    int            frames_in_q = 0;
    int            pop_idx = 0;
    int            first_cyc = 0;
    int            last_frame_len = 0;
    bit            post_rst = 1'b0;
    bit            stall_prev = 1'b0;
    bit            swap_prev = 1'b0;
    logic          ctrl_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic          last_prev = 1'b0;

    always @(negedge clk) begin
        logic          is_last;
        logic [DW-1:0] e_data;
        logic          e_last;
        chk("din2_zero", 32'(din2), 0);
        chk("tie_offs", 32'({rd_en1, wr_en2, rd_addr1, wr_addr2}), 0);
        if (!CLEAR_EN) chk("clear_tied", 32'(clear), 0);
        if (clear) chk("clear_busy", 32'(busy), 1);
        if (rst) begin
            chk("rst_wr_en1", 32'(wr_en1), 0);
            chk("rst_rd_en2", 32'(rd_en2), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            exp_data.delete();
            exp_last.delete();
            model_fill  = 0;
            frames_in_q = 0;
            pop_idx     = 0;
            stall_prev  = 1'b0;
            swap_prev   = 1'b0;
            post_rst    = 1'b1;
        end else begin
            if (post_rst) begin
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_out_last", 32'(out_last), 0);
                chk("rst_ctrl", 32'(ctrl), 0);
                chk("rst_busy", 32'(busy), 32'(CLEAR_EN));
                post_rst = 1'b0;
            end
            if (stall_prev) begin
                chk("stall_valid_held", 32'(out_valid), 1);
                chk("stall_data_held", 32'(out_data), 32'(data_prev));
                chk("stall_last_held", 32'(out_last), 32'(last_prev));
            end
            if (swap_prev) chk("swap_toggle", 32'(ctrl), 32'(!ctrl_prev));
            if (busy && !clear) begin
                chk("swap_one_frame_pending", 32'(frames_in_q), 1);
                chk("swap_in_ready", 32'(in_ready), 0);
            end
            if (out_valid && !out_ready) chk("stall_rd_en2", 32'(rd_en2), 0);

            if (in_valid && in_ready) begin
                is_last = in_last || (model_fill == DEPTH - 1);
                exp_data.push_back(in_data);
                exp_last.push_back(is_last);
                if (is_last) begin
                    model_fill = 0;
                    frames_in_q++;
                end else begin
                    model_fill++;
                end
            end

            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e_data = exp_data.pop_front();
                    e_last = exp_last.pop_front();
                    chk("out_data", 32'(out_data), 32'(e_data));
                    chk("out_last", 32'(out_last), 32'(e_last));
                    if (pop_idx == 0) first_cyc = cyc;
                    pop_idx++;
                    if (e_last) begin
                        if (tput_len != 0 && pop_idx == tput_len) begin
                            chk("drain_tput", 32'(cyc - first_cyc), 32'(tput_len - 1));
                            tput_len = 0;
                        end
                        last_frame_len = pop_idx;
                        frames_in_q--;
                        pop_idx = 0;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            last_prev  = out_last;
            swap_prev  = busy && !clear;
            ctrl_prev  = ctrl;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit with_last, input int gap_max, input int base);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_beat((base >= 0) ? DW'(base + i) : DW'($urandom), with_last && (i == len - 1));
        end
        frames_sent++;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((exp_data.size() != 0 || busy || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", 32'(exp_data.size() == 0 && !busy && !out_valid), 1);
        chk("ctrl_parity", 32'(ctrl), 32'(frames_sent % 2));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(input int n);
        int t = 0;
        while (pop_idx < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (pop_idx < n) chk("pop_timeout", 32'(pop_idx), 32'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        in_valid    = 1'b0;
        frames_sent = 0;
    endtask

    initial begin
        int c0;
        int t;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;

        if (CLEAR_EN) begin
            for (int i = 0; i < DEPTH; i++) begin
                @(negedge clk);
                chk("clear_active", 32'(clear), 1);
                chk("clear_addr", 32'(wr_addr1), 32'(i));
                chk("clear_in_ready", 32'(in_ready), 0);
            end
            @(negedge clk);
            chk("clear_done_busy", 32'(busy), 0);
            chk("clear_done_in_ready", 32'(in_ready), 1);
        end
        wait_idle();

        // Full-depth frame at full rate, first swap moves ctrl to 1.
        ready_mode = 0;
        tput_len   = 16;
        c0 = cyc;
        send_frame(16, 1'b0, 0, 0);
        chk("fill_tput", 32'(cyc - c0), 16);
        @(negedge clk);
        chk("fill_done_in_ready", 32'(in_ready), 0);
        t = 0;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("swap_seen", 32'(busy), 1);
        @(negedge clk);
        chk("first_swap_ctrl", 32'(ctrl), 1);
        wait_idle();

        // Short frame terminated by in_last.
        send_frame(5, 1'b1, 1, -1);
        wait_idle();
        chk("frame5_len", 32'(last_frame_len), 5);

        // Downstream stall mid-drain.
        send_frame(12, 1'b1, 0, -1);
        wait_pop(3);
        ready_mode = 2;
        repeat (10) @(posedge clk);
        #1;
        ready_mode = 0;
        wait_idle();
        chk("frame12_len", 32'(last_frame_len), 12);

        // Second frame fills while the first drains slowly.
        ready_mode = 1;
        send_frame(8, 1'b1, 0, -1);
        send_frame(10, 1'b1, 0, -1);
        @(negedge clk);
        chk("second_fill_blocks", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        wait_idle();

        // Randomized back-to-back frames.
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 16);
            ready_mode = $urandom_range(0, 1);
            send_frame(len, (len < 16) ? 1'b1 : 1'($urandom_range(0, 1)), 2, -1);
        end
        ready_mode = 0;
        wait_idle();

        // Reset mid-fill, then a clean frame.
        send_frame(5, 1'b0, 0, -1);
        frames_sent = 0;
        do_reset();
        send_frame(7, 1'b1, 0, -1);
        wait_idle();
        chk("post_rst_fill_len", 32'(last_frame_len), 7);

        // Reset mid-drain, then a clean frame.
        ready_mode = 1;
        send_frame(12, 1'b1, 0, -1);
        wait_pop(2);
        do_reset();
        ready_mode = 0;
        send_frame(6, 1'b1, 0, -1);
        wait_idle();
        chk("post_rst_drain_len", 32'(last_frame_len), 6);
        chk("queue_empty", 32'(exp_data.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
